// File: rtl/piso_scan_serializer_pkg.sv
// Shared definitions for the PISO scan serializer.
//   DATA_W  : parallel word width
//   CNT_W   : beat counter width (log2 DATA_W)
//   state_e : frame state (PARITY is only reached when PISO_PARITY_EN is defined)
package piso_pkg;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;
endpackage

// File: rtl/piso_scan_serializer_if.sv
// Load / serial handshake bundle for the PISO scan serializer.
//   load_valid, load_ready, load_data : parallel word in (valid/ready)
//   ser_ready, ser_valid, ser_out, ser_last : serial bit out (valid/ready)
//   busy : frame in progress
// slave  = serializer side, master = upstream/downstream side.
interface piso_scan_serializer_if;
    import piso_pkg::*;

    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              ser_ready;
    logic              ser_valid;
    logic              ser_out;
    logic              ser_last;
    logic              busy;

    modport slave (
        input  load_valid, load_data, ser_ready,
        output load_ready, ser_valid, ser_out, ser_last, busy
    );

    modport master (
        output load_valid, load_data, ser_ready,
        input  load_ready, ser_valid, ser_out, ser_last, busy
    );
endinterface

// File: rtl/piso_scan_serializer_mux.sv
// MUX8x1_design: existing 8:1 bit mux.
//   i : 8 input bits
//   s : select, bit-reversed (s[0] is the MSB of the index)
//   y : i[{s[0], s[1], s[2]}]
module MUX8x1_design (
    input  logic [7:0] i,
    input  logic [2:0] s,
    output logic       y
);
    assign y = i[{s[0], s[1], s[2]}];
endmodule

// File: rtl/piso_scan_serializer.sv
// piso_scan_serializer: accepts an 8-bit word in IDLE and shifts it out LSB
// first, one bit per ser_valid && ser_ready beat.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : piso_scan_serializer_if.slave (load side, serial side, busy)
// Build option: define PISO_PARITY_EN to append an even-parity beat to each
// frame (ser_last then marks the parity beat instead of data bit 7).
module piso_scan_serializer
    import piso_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    piso_scan_serializer_if.slave     bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  bit_cnt, cnt_d;
    logic              mux_bit;
    logic              ser_out, ser_last;

    // The mux takes its select bit-reversed, so feed it a reversed count;
    // the two reversals cancel and it picks data_q[bit_cnt].
    MUX8x1_design u_mux (
        .i (data_q),
        .s ({bit_cnt[0], bit_cnt[1], bit_cnt[2]}),
        .y (mux_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            bit_cnt <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            bit_cnt <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = bit_cnt;
        case (state_q)
            IDLE: begin
                // load_ready is 1 only here, so load_valid alone accepts
                if (bus.load_valid) begin
                    state_d = SHIFT;
                    data_d  = bus.load_data;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (bus.ser_ready) begin
                    cnt_d = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_CNT) begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (bus.ser_ready) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on registered state only.
    always_comb begin
        ser_out  = 1'b0;
        ser_last = 1'b0;
        case (state_q)
            SHIFT: begin
                ser_out = mux_bit;
`ifndef PISO_PARITY_EN
                ser_last = (bit_cnt == LAST_CNT);
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                ser_out  = ^data_q;
                ser_last = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.ser_valid  = (state_q != IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.ser_out    = ser_out;
    assign bus.ser_last   = ser_last;
endmodule

// File: tb/tb_piso_scan_serializer.sv
module tb_piso_scan_serializer;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int FRAME_CYC = 10;
`else
    localparam bit PAR = 1'b0;
    localparam int FRAME_CYC = 9;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    piso_scan_serializer_if bus ();
    piso_scan_serializer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // exp = {ser_valid, ser_out, ser_last, load_ready, busy} after the edge
    typedef struct packed {
        logic       lv;
        logic [7:0] ld;
        logic       sr;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(logic lv, logic [7:0] ld, logic sr,
                                logic v, logic o, logic l);
        vec_t e;
        e.lv  = lv;
        e.ld  = ld;
        e.sr  = sr;
        e.exp = {v, o, l, ~v, v};
        vecs.push_back(e);
    endfunction

    // Steps after data beat 7 completes (ready high): optional parity beat, then IDLE.
    function automatic void tail(logic par, logic lv, logic [7:0] junk);
        if (PAR) add(lv, junk, 1'b1, 1'b1, par, 1'b1);
        add(lv, junk, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    // Full frame with ready held high; lv/junk driven on the load port meanwhile.
    function automatic void frame(logic [7:0] d, logic par, logic hold_lv, logic [7:0] junk);
        add(1'b1, d, 1'b1, 1'b1, d[0], 1'b0);
        for (int k = 1; k < 8; k++)
            add(hold_lv, junk, 1'b1, 1'b1, d[k], (k == 7) && !PAR);
        tail(par, hold_lv, junk);
    endfunction

    function automatic logic [4:0] outs();
        return {bus.ser_valid, bus.ser_out, bus.ser_last, bus.load_ready, bus.busy};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h (b%b) expected %0h (b%b)", name, act, act, exp, exp);
        end
    endtask

    initial begin
        int  cyc;
        bit  got;
        logic lr;

        rst_n          = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.ser_ready  = 1'b0;

        // ---------------- vector table ----------------
        // 8'hA5, ready high: 1,0,1,0,0,1,0,1, last on beat 7
        add(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, !PAR);
        tail(1'b0, 1'b0, 8'h00);
        // idle with ready/data wiggling: nothing happens
        add(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        // 8'h01 with ready toggling 0/1: each beat held through its stall
        add(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            add(1'b0, 8'h00, 1'b0, 1'b1, k == 0, (k == 7) && !PAR);
            if (k < 7) add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, (k + 1 == 7) && !PAR);
        end
        tail(1'b1, 1'b0, 8'h00);
        // 8'h3C with load_valid/8'hFF held during the frame: must be ignored
        frame(8'h3C, 1'b0, 1'b1, 8'hFF);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef PISO_PARITY_EN
        frame(8'h07, 1'b1, 1'b0, 8'h00);
        frame(8'h03, 1'b0, 1'b0, 8'h00);
`endif

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'(5'b00010));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.load_valid = vecs[i].lv;
            bus.load_data  = vecs[i].ld;
            bus.ser_ready  = vecs[i].sr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // ---------------- reset mid-frame ----------------
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hF0;
        bus.ser_ready  = 1'b1;
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_beat4", 32'(outs()), 32'(5'b11001));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_async", 32'(outs()), 32'(5'b00010));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postrst%0d", c), 32'(outs()), 32'(5'b00010));
        end

        // ---------------- back-to-back 8'h55 then 8'hAA ----------------
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h55;
        bus.ser_ready  = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_first", 32'(outs()), 32'(5'b11001));
        bus.load_data = 8'hAA;
        cyc = 0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            lr = bus.load_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (lr) got = 1'b1;
        end
        if (!got) chk("b2b_timeout", 32'd0, 32'd1);
        chk("b2b_period", 32'(cyc), 32'(FRAME_CYC));
        chk("b2b_second", 32'(outs()), 32'(5'b10001));
        bus.load_valid = 1'b0;
        repeat (FRAME_CYC + 2) @(posedge clk);
        #1;
        chk("b2b_drain", 32'(outs()), 32'(5'b00010));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
